// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default latencies for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1
  } ctrl_state_t;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 12;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns hazard, redirect, memory wait and mul/div
// occupancy into per-stage load enables, bubbles/flushes and perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic             flush_req,
  input  logic             dmem_wait,
  input  logic             mdu_start,
  input  logic             mdu_is_div,
  input  logic             cnt_clr,
  output logic             en_pc,
  output logic             en_s2,
  output logic             en_s3,
  output logic             en_s4,
  output logic             en_s5,
  output logic             en_s6,
  output logic             flush_s2,
  output logic             bubble_s3,
  output logic             bubble_s4,
  output logic             mdu_ce,
  output logic             mdu_ready,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = $clog2(DIV_LAT) + 1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  ctrl_state_t   state_r, state_nxt_s;
  logic [CW-1:0] mdu_cnt_r, mdu_cnt_nxt_s;

  // State and occupancy counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      mdu_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      mdu_cnt_r <= mdu_cnt_nxt_s;
    end
  end

  // Next-state and Mealy output decode, highest priority first.
  always_comb begin
    state_nxt_s   = state_r;
    mdu_cnt_nxt_s = mdu_cnt_r;
    en_pc         = 1'b1;
    en_s2         = 1'b1;
    en_s3         = 1'b1;
    en_s4         = 1'b1;
    en_s5         = 1'b1;
    en_s6         = 1'b1;
    flush_s2      = 1'b0;
    bubble_s3     = 1'b0;
    bubble_s4     = 1'b0;
    mdu_ce        = 1'b0;
    mdu_ready     = 1'b0;
    if (dmem_wait) begin
      // Whole pipe frozen; the MDU clock is gated so occupancy stretches.
      en_pc = 1'b0;
      en_s2 = 1'b0;
      en_s3 = 1'b0;
      en_s4 = 1'b0;
      en_s5 = 1'b0;
      en_s6 = 1'b0;
    end else if ((state_r == RUN) && mdu_start) begin
      en_pc         = 1'b0;
      en_s2         = 1'b0;
      en_s3         = 1'b0;
      bubble_s4     = 1'b1;
      mdu_ce        = 1'b1;
      mdu_cnt_nxt_s = mdu_is_div ? DIV_LOAD : MUL_LOAD;
      state_nxt_s   = MDU_BUSY;
    end else if ((state_r == MDU_BUSY) && (mdu_cnt_r > CNT_ONE)) begin
      en_pc         = 1'b0;
      en_s2         = 1'b0;
      en_s3         = 1'b0;
      bubble_s4     = 1'b1;
      mdu_ce        = 1'b1;
      mdu_cnt_nxt_s = mdu_cnt_r - CNT_ONE;
    end else begin
      if (state_r == MDU_BUSY) begin
        mdu_ready     = 1'b1;
        mdu_ce        = 1'b1;
        mdu_cnt_nxt_s = '0;
        state_nxt_s   = RUN;
      end else begin
        state_nxt_s = RUN;
      end
      // A hazard stall suppresses the redirect; the branch resolves again next cycle.
      if (hazard_stall) begin
        en_pc     = 1'b0;
        en_s2     = 1'b0;
        bubble_s3 = 1'b1;
      end else if (flush_req) begin
        flush_s2 = 1'b1;
      end else begin
        flush_s2 = 1'b0;
      end
    end
  end

  assign ctrl_state = state_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~en_pc),
    .clr   (cnt_clr),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_s2),
    .clr   (cnt_clr),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expected controls go through a scoreboard
// queue; a small saturating model tracks the expected performance counters.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  // Input vector: {dmem_wait, hazard_stall, flush_req, mdu_start, mdu_is_div, cnt_clr}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_CLR   = 6'b000001;
  localparam logic [5:0] I_MUL   = 6'b000100;
  localparam logic [5:0] I_DIV   = 6'b000110;
  localparam logic [5:0] I_FLUSH = 6'b001000;
  localparam logic [5:0] I_HAZ   = 6'b010000;
  localparam logic [5:0] I_WAIT  = 6'b100000;

  // Output vector: {en_pc..en_s6, flush_s2, bubble_s3, bubble_s4, mdu_ce, mdu_ready}
  localparam logic [10:0] E_IDLE  = 11'b111111_00000;
  localparam logic [10:0] E_MDU   = 11'b000111_00110;
  localparam logic [10:0] E_RDY   = 11'b111111_00011;
  localparam logic [10:0] E_RDYF  = 11'b111111_10011;
  localparam logic [10:0] E_WAIT  = 11'b000000_00000;
  localparam logic [10:0] E_HAZ   = 11'b001111_01000;
  localparam logic [10:0] E_FLUSH = 11'b111111_10000;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hazard_stall = 1'b0, flush_req = 1'b0, dmem_wait = 1'b0;
  logic             mdu_start = 1'b0, mdu_is_div = 1'b0, cnt_clr = 1'b0;
  logic             en_pc, en_s2, en_s3, en_s4, en_s5, en_s6;
  logic             flush_s2, bubble_s3, bubble_s4, mdu_ce, mdu_ready;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [12:0]      exp_q[$];
  logic [CNT_W-1:0] stall_m = '0;
  logic [CNT_W-1:0] flush_m = '0;

  pipe_ctrl #(.MUL_LAT(4), .DIV_LAT(12), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .flush_req(flush_req),
    .dmem_wait(dmem_wait), .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
    .cnt_clr(cnt_clr), .en_pc(en_pc), .en_s2(en_s2), .en_s3(en_s3), .en_s4(en_s4),
    .en_s5(en_s5), .en_s6(en_s6), .flush_s2(flush_s2), .bubble_s3(bubble_s3),
    .bubble_s4(bubble_s4), .mdu_ce(mdu_ce), .mdu_ready(mdu_ready),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  // One clock cycle: drive, score comb outputs at negedge, score counters after the edge.
  task automatic step(input logic [5:0] in, input logic [10:0] exp, input logic [1:0] st);
    logic [12:0] e;
    step_no++;
    {dmem_wait, hazard_stall, flush_req, mdu_start, mdu_is_div, cnt_clr} = in;
    exp_q.push_back({st, exp});
    @(negedge clk);
    e = exp_q.pop_front();
    check("ctrl_out", {21'd0, en_pc, en_s2, en_s3, en_s4, en_s5, en_s6,
                       flush_s2, bubble_s3, bubble_s4, mdu_ce, mdu_ready}, {21'd0, e[10:0]});
    check("ctrl_state", {30'd0, ctrl_state}, {30'd0, e[12:11]});
    if (in[0]) begin
      stall_m = '0;
      flush_m = '0;
    end else begin
      if (!e[10] && (stall_m != '1)) stall_m = stall_m + 4'd1;
      if (e[4] && (flush_m != '1)) flush_m = flush_m + 4'd1;
    end
    @(posedge clk);
    #1;
    check("stall_cnt", {28'd0, stall_cnt}, {28'd0, stall_m});
    check("flush_cnt", {28'd0, flush_cnt}, {28'd0, flush_m});
  endtask

  initial begin
    // Power-on reset
    #1;
    check("rst_state", {30'd0, ctrl_state}, 32'd0);
    check("rst_stall", {28'd0, stall_cnt}, 32'd0);
    check("rst_flush", {28'd0, flush_cnt}, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(I_NONE, E_IDLE, S_RUN);

    // Load-use stall with a simultaneous redirect: redirect suppressed
    step(I_HAZ | I_FLUSH, E_HAZ, S_RUN);
    check("loaduse_stall1", {28'd0, stall_cnt}, 32'd1);
    step(I_NONE, E_IDLE, S_RUN);

    // Flush alone
    step(I_FLUSH, E_FLUSH, S_RUN);
    check("flush_cnt1", {28'd0, flush_cnt}, 32'd1);

    // Multiply: 3 held cycles then ready in cycle 4
    step(I_MUL, E_MDU, S_RUN);
    step(I_MUL, E_MDU, S_BUSY);
    step(I_MUL, E_MDU, S_BUSY);
    step(I_MUL, E_RDY, S_BUSY);
    step(I_NONE, E_IDLE, S_RUN);

    // Multiply: hazard/flush ignored while busy, flush honoured with ready
    step(I_MUL | I_FLUSH, E_MDU, S_RUN);
    step(I_MUL | I_HAZ, E_MDU, S_BUSY);
    step(I_MUL | I_FLUSH, E_MDU, S_BUSY);
    step(I_MUL | I_FLUSH, E_RDYF, S_BUSY);
    step(I_FLUSH | I_WAIT, E_WAIT, S_RUN);

    // Clear both counters
    step(I_CLR, E_IDLE, S_RUN);

    // Divide with two wait cycles mid-occupancy: ready in cycle 14
    step(I_DIV, E_MDU, S_RUN);
    for (int i = 0; i < 3; i++) step(I_DIV, E_MDU, S_BUSY);
    for (int i = 0; i < 2; i++) step(I_DIV | I_WAIT, E_WAIT, S_BUSY);
    for (int i = 0; i < 7; i++) step(I_DIV, E_MDU, S_BUSY);
    step(I_DIV, E_RDY, S_BUSY);
    check("div_stall13", {28'd0, stall_cnt}, 32'd13);
    step(I_NONE, E_IDLE, S_RUN);

    // Reset in the middle of a divide: abandoned, no ready pulse afterwards
    step(I_DIV, E_MDU, S_RUN);
    step(I_DIV, E_MDU, S_BUSY);
    rst_n = 1'b0;
    #1;
    check("midrst_state", {30'd0, ctrl_state}, 32'd0);
    check("midrst_stall", {28'd0, stall_cnt}, 32'd0);
    check("midrst_flush", {28'd0, flush_cnt}, 32'd0);
    stall_m = '0;
    flush_m = '0;
    {dmem_wait, hazard_stall, flush_req, mdu_start, mdu_is_div, cnt_clr} = I_NONE;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(I_NONE, E_IDLE, S_RUN);
    step(I_NONE, E_IDLE, S_RUN);

    // Saturation: 20 stall cycles on a 4-bit counter, then clear beats increment
    for (int i = 0; i < 20; i++) step(I_HAZ, E_HAZ, S_RUN);
    check("stall_sat", {28'd0, stall_cnt}, 32'd15);
    step(I_HAZ, E_HAZ, S_RUN);
    check("stall_sat_hold", {28'd0, stall_cnt}, 32'd15);
    step(I_HAZ | I_CLR, E_HAZ, S_RUN);
    check("stall_clr", {28'd0, stall_cnt}, 32'd0);
    step(I_NONE, E_IDLE, S_RUN);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 6-stage MIPS core. It turns the forwarding unit's `stall_pipe`, the stage-2 branch/jump redirect, data-memory wait and multi-cycle mul/div occupancy of stage 3 into per-stage register enables, bubble/flush controls and a mul/div clock-enable. It also keeps saturating stall/flush performance counters. It sits beside the forwarding unit and drives every pipeline register load enable.

## Interface
- `MUL_LAT`, default 4: cycles a multiply occupies s3, including the issue cycle; must be ≥2.
- `DIV_LAT`, default 12: cycles a divide occupies s3, including the issue cycle; must be ≥2.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hazard_stall` in 1: `stall_pipe` from the forwarding unit.
- `flush_req` in 1: taken branch or jump resolved in s2.
- `dmem_wait` in 1: data memory not ready; freezes the whole pipe.
- `mdu_start` in 1: the s3 instruction is mul/div; held while it sits in s3.
- `mdu_is_div` in 1: qualifies `mdu_start`; 1 selects `DIV_LAT`.
- `cnt_clr` in 1: synchronous clear of both counters.
- `en_pc`, `en_s2`, `en_s3`, `en_s4`, `en_s5`, `en_s6` out 1 each: load enables for the PC and the input registers of stages 2–6.
- `flush_s2` out 1: the s2 register loads a NOP.
- `bubble_s3` out 1: the s3 register loads a NOP.
- `bubble_s4` out 1: the s4 register loads a NOP.
- `mdu_ce` out 1: mul/div unit clock enable.
- `mdu_ready` out 1: the mul/div result is valid this cycle.
- `ctrl_state` out 2: current FSM state.
- `stall_cnt` out CNT_W: saturating stall-cycle counter.
- `flush_cnt` out CNT_W: saturating flush counter.

## Operation
- **States:** RUN=0, MDU_BUSY=1. Internal down-counter `mdu_cnt`, width `$clog2(DIV_LAT)+1`.
- **Default outputs:** all `en_*`=1; `flush_s2`, `bubble_*`, `mdu_ce`, `mdu_ready`=0.
- **Priority, evaluated combinationally each cycle:**
  1. `dmem_wait`=1 (any state): all `en_*`=0, no bubble/flush, `mdu_ce`=0. State and `mdu_cnt` hold. Counters still count.
  2. RUN & `mdu_start` (issue cycle):
     - `en_pc`/`en_s2`/`en_s3`=0; `en_s4`=1 with `bubble_s4`=1; `mdu_ce`=1.
     - `mdu_cnt` ← LAT−1 (LAT = `mdu_is_div` ? `DIV_LAT` : `MUL_LAT`).
     - Next state MDU_BUSY.
     - `hazard_stall` and `flush_req` are ignored this cycle.
  3. MDU_BUSY & `mdu_cnt`>1: same holds/bubble as the issue cycle, `mdu_ce`=1, `mdu_cnt` decrements. `hazard_stall` and `flush_req` are ignored.
  4. MDU_BUSY & `mdu_cnt`==1:
     - `mdu_ready`=1, `mdu_ce`=1, all `en_*`=1; the mul/div instruction advances with its result.
     - `hazard_stall` and `flush_req` are honoured as in rules 5 and 6.
     - Next state RUN.
  5. `hazard_stall`: `en_pc`=`en_s2`=0, `bubble_s3`=1, `flush_req` ignored. The branch is re-evaluated next cycle.
  6. `flush_req`: `flush_s2`=1, all `en_*`=1.
- **`stall_cnt`:** +1 in every cycle with `en_pc`=0.
- **`flush_cnt`:** +1 in every cycle with `flush_s2`=1.
- **Counter rules:** both saturate at all-ones. `cnt_clr` wins over an increment in the same cycle.

## Timing
- `en_*`, `flush_s2`, `bubble_*`, `mdu_ce` and `mdu_ready` are combinational (Mealy) from state, `mdu_cnt` and inputs; they take effect at the next rising edge.
- A mul/div holds s3 for exactly LAT non-waiting cycles; `mdu_ready` is high in the last of them.
- A `dmem_wait` cycle extends an MDU occupancy by one cycle per wait cycle.
- **Reset:** asynchronous on `rst_n`=0. State=RUN, `mdu_cnt`=0, `stall_cnt`=`flush_cnt`=0, `ctrl_state`=0. With all inputs low, every `en_*`=1 and all other outputs are 0.
- **Reset mid-MDU:** the occupancy is abandoned; no `mdu_ready` pulse is issued.

## Structure
- `pipe_ctrl_pkg`: `ctrl_state_t` enum (RUN, MDU_BUSY) and default latency constants `MUL_LAT_DEF`=4 and `DIV_LAT_DEF`=12.
- One sub-module, `sat_counter` (parameters `W`; ports `clk`, `rst_n`, `inc`, `clr`, `q`), instantiated twice for the performance counters.
- FSM, `mdu_cnt` and the output decode live in `pipe_ctrl`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-MDU_BUSY → `ctrl_state`=0 and both counters 0 immediately; after release, all `en_*`=1.
- **Load-use stall:** `hazard_stall`=1 for 1 cycle with `flush_req`=1 → `en_pc`=`en_s2`=0, `bubble_s3`=1, `flush_s2`=0, `stall_cnt`=1.
- **Multiply:** `mdu_start`=1, `mdu_is_div`=0 → 3 cycles with `en_s3`=0 and `bubble_s4`=1, then `mdu_ready`=1 in cycle 4 and state returns to RUN.
- **Divide with wait:** divide plus `dmem_wait`=1 for 2 cycles mid-occupancy → `mdu_ready` in cycle 14, `mdu_ce` low exactly 2 cycles, `stall_cnt`=13.
- **Flush:** `flush_req`=1 alone → `flush_s2`=1, all `en_*`=1, `flush_cnt` increments. `flush_req` in the cycle `mdu_ready`=1 → also flushes.
- **Counter saturation and clear:** with `CNT_W`=4, 20 stall cycles → `stall_cnt`=15 and holds. `cnt_clr` together with a stall → 0.
